// File: rtl/regfile_arb_pkg.sv
// Shared widths, the hardwired-zero register index and requester IDs for the regfile write arbiter.
package regfile_arb_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int REG_ZERO     = 0;

    typedef enum logic [1:0] {
        REQ_WB = 2'd0,
        REQ_MD = 2'd1,
        REQ_IO = 2'd2
    } req_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin: combinational grant, and a pointer that moves past the winner on advance.
// Side A has priority after reset; grants are zero-latency; each requester simply waits while not granted.
module rr_arbiter2 (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_a,
    output logic gnt_b
);
    logic ptr_b;

    always_comb begin
        gnt_a = req_a & (~req_b | ~ptr_b);
        gnt_b = req_b & (~req_a | ptr_b);
    end

    // After a grant the other side gets priority on the next contention.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            ptr_b <= 1'b0;
        end else if (advance) begin
            ptr_b <= gnt_a;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Regfile write-port arbiter (WB > round-robin MD/IO) with an MD busy scoreboard; one-cycle registered write.
// WB is never stalled; MD/IO wait on ready. Define REGFILE_ARB_FWD_EN to add the fwd_hitA/fwd_hitB/fwd_data bypass.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                md_valid,
    output logic                md_ready,
    input  logic [ADDR_W-1:0]   md_reg,
    input  logic [DATA_W-1:0]   md_data,
    input  logic                io_valid,
    output logic                io_ready,
    input  logic [ADDR_W-1:0]   io_reg,
    input  logic [DATA_W-1:0]   io_data,
    input  logic                md_issue,
    input  logic [ADDR_W-1:0]   md_issue_reg,
    input  logic [ADDR_W-1:0]   rd_regA,
    input  logic [ADDR_W-1:0]   rd_regB,
    output logic                stall_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                ctrl_writeEnable,
    output logic [ADDR_W-1:0]   ctrl_writeReg,
    output logic [DATA_W-1:0]   data_writeReg
`ifdef REGFILE_ARB_FWD_EN
    ,
    output logic                fwd_hitA,
    output logic                fwd_hitB,
    output logic [DATA_W-1:0]   fwd_data
`endif
);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic                md_req, io_req, md_gnt, io_gnt;
    logic                fire;
    req_id_t             src;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // WB pre-empts the MD/IO arbitration outright; nothing is offered during reset.
    assign md_req = md_valid & ~wb_valid & ~ctrl_reset;
    assign io_req = io_valid & ~wb_valid & ~ctrl_reset;

    rr_arbiter2 u_rr (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req_a      (md_req),
        .req_b      (io_req),
        .advance    (md_gnt | io_gnt),
        .gnt_a      (md_gnt),
        .gnt_b      (io_gnt)
    );

    assign md_ready = md_gnt;
    assign io_ready = io_gnt;

    always_comb begin
        src  = REQ_WB;
        fire = 1'b0;
        if (!ctrl_reset) begin
            if (wb_valid) begin
                src  = REQ_WB;
                fire = 1'b1;
            end else if (md_gnt) begin
                src  = REQ_MD;
                fire = 1'b1;
            end else if (io_gnt) begin
                src  = REQ_IO;
                fire = 1'b1;
            end
        end
    end

    always_comb begin
        sel_reg  = wb_reg;
        sel_data = wb_data;
        case (src)
            REQ_MD: begin
                sel_reg  = md_reg;
                sel_data = md_data;
            end
            REQ_IO: begin
                sel_reg  = io_reg;
                sel_data = io_data;
            end
            default: begin
                sel_reg  = wb_reg;
                sel_data = wb_data;
            end
        endcase
    end

    // Writes to r0 complete their handshake but are swallowed here.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (fire && sel_reg != ZERO_IDX) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= sel_reg;
            data_writeReg    <= sel_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    // Issue is applied after the MD completion clear so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (md_gnt) begin
            busy_d[md_reg] = 1'b0;
        end
        if (md_issue && md_issue_reg != ZERO_IDX) begin
            busy_d[md_issue_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec   = busy_q;
    assign stall_busy = busy_q[rd_regA] | busy_q[rd_regB];

`ifdef REGFILE_ARB_FWD_EN
    assign fwd_hitA = ctrl_writeEnable & (ctrl_writeReg == rd_regA);
    assign fwd_hitB = ctrl_writeEnable & (ctrl_writeReg == rd_regB);
    assign fwd_data = data_writeReg;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          wb_valid, md_valid, io_valid, md_issue;
    logic [AW-1:0] wb_reg, md_reg, io_reg, md_issue_reg, rd_regA, rd_regB;
    logic [DW-1:0] wb_data, md_data, io_data;
    logic          md_ready, io_ready, stall_busy, ctrl_writeEnable;
    logic [NR-1:0] busy_vec;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
`ifdef REGFILE_ARB_FWD_EN
    logic          fwd_hitA, fwd_hitB;
    logic [DW-1:0] fwd_data;
`endif

    regfile_write_arbiter dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
        .io_valid(io_valid), .io_ready(io_ready), .io_reg(io_reg), .io_data(io_data),
        .md_issue(md_issue), .md_issue_reg(md_issue_reg),
        .rd_regA(rd_regA), .rd_regB(rd_regB),
        .stall_busy(stall_busy), .busy_vec(busy_vec),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg)
`ifdef REGFILE_ARB_FWD_EN
        , .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB), .fwd_data(fwd_data)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what the write port and scoreboard should show now.
    bit          m_ptr_io;
    bit [NR-1:0] m_busy;
    bit          m_we;
    bit [AW-1:0] m_wreg;
    bit [DW-1:0] m_wdata;
    bit          m_wr_known;
    logic        got_md_rdy, got_io_rdy, got_stall;

    task automatic model_reset();
        m_ptr_io = 1'b0; m_busy = '0; m_we = 1'b0;
        m_wreg = '0; m_wdata = '0; m_wr_known = 1'b1;
    endtask

    // One clock: check outputs vs model, then advance the model with this cycle's inputs.
    task automatic tick();
        bit e_md, e_io, go;
        bit [AW-1:0] w_reg;
        bit [DW-1:0] w_dat;
        #1;
        e_md = !ctrl_reset && md_valid && !wb_valid && (!io_valid || !m_ptr_io);
        e_io = !ctrl_reset && io_valid && !wb_valid && (!md_valid || m_ptr_io);
        check("md_ready", 64'(md_ready), 64'(e_md));
        check("io_ready", 64'(io_ready), 64'(e_io));
        check("we", 64'(ctrl_writeEnable), 64'(m_we));
        if (m_wr_known) begin
            check("wreg", 64'(ctrl_writeReg), 64'(m_wreg));
            check("wdata", 64'(data_writeReg), 64'(m_wdata));
        end
        check("busy_vec", 64'(busy_vec), 64'(m_busy));
        check("stall", 64'(stall_busy), 64'(m_busy[rd_regA] | m_busy[rd_regB]));
`ifdef REGFILE_ARB_FWD_EN
        check("fwd_hitA", 64'(fwd_hitA), 64'(m_we && m_wreg == rd_regA));
        check("fwd_hitB", 64'(fwd_hitB), 64'(m_we && m_wreg == rd_regB));
        if (m_wr_known) check("fwd_data", 64'(fwd_data), 64'(m_wdata));
`endif
        got_md_rdy = md_ready;
        got_io_rdy = io_ready;
        got_stall  = stall_busy;
        @(posedge clock);
        if (ctrl_reset) begin
            model_reset();
        end else begin
            if (e_md) m_busy[md_reg] = 1'b0;
            if (md_issue && md_issue_reg != 0) m_busy[md_issue_reg] = 1'b1;
            go = 1'b1; w_reg = '0; w_dat = '0;
            if (wb_valid)  begin w_reg = wb_reg; w_dat = wb_data; end
            else if (e_md) begin w_reg = md_reg; w_dat = md_data; end
            else if (e_io) begin w_reg = io_reg; w_dat = io_data; end
            else go = 1'b0;
            m_we = go && (w_reg != 0);
            if (m_we) begin
                m_wreg = w_reg; m_wdata = w_dat; m_wr_known = 1'b1;
            end else if (go) begin
                m_wr_known = 1'b0;
            end
            if (e_md) m_ptr_io = 1'b1;
            else if (e_io) m_ptr_io = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic quiet();
        wb_valid = 0; md_valid = 0; io_valid = 0; md_issue = 0;
        rd_regA = '0; rd_regB = '0;
    endtask

    initial begin
        quiet();
        wb_reg = '0; md_reg = '0; io_reg = '0; md_issue_reg = '0;
        wb_data = '0; md_data = '0; io_data = '0;
        ctrl_reset = 1'b1;
        wb_valid = 1; md_valid = 1; io_valid = 1;
        @(posedge clock);
        @(negedge clock);
        model_reset();

        // Reset: readys stay low with everything valid, state clear afterwards.
        tick();
        check("rst_we", 64'(ctrl_writeEnable), 64'd0);
        check("rst_busy", 64'(busy_vec), 64'd0);
        ctrl_reset = 0; wb_valid = 0;
        md_reg = 5'd6; md_data = 32'h0000_0606;
        io_reg = 5'd2; io_data = 32'h0000_0202;
        tick();
        check("first_grant_md", 64'(got_md_rdy), 64'd1);

        // WB priority over held MD/IO requests.
        wb_valid = 1; wb_reg = 5'd5; wb_data = 32'hAAAA_0001;
        tick();
        check("prio_md_rdy", 64'(got_md_rdy), 64'd0);
        check("prio_io_rdy", 64'(got_io_rdy), 64'd0);
        check("prio_we", 64'(ctrl_writeEnable), 64'd1);
        check("prio_reg", 64'(ctrl_writeReg), 64'd5);
        check("prio_data", 64'(data_writeReg), 64'hAAAA_0001);

        // Round-robin from a fresh pointer.
        wb_valid = 0; ctrl_reset = 1;
        tick();
        ctrl_reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_order", got_md_rdy ? 64'd1 : 64'd2, (i % 2 == 0) ? 64'd1 : 64'd2);
            check("rr_we", 64'(ctrl_writeEnable), 64'd1);
            check("rr_reg", 64'(ctrl_writeReg), (i % 2 == 0) ? 64'd6 : 64'd2);
        end

        // r0 write completes the handshake but never reaches the regfile.
        md_valid = 0; io_valid = 1; io_reg = '0; io_data = 32'hFFFF_FFFF;
        tick();
        check("r0_ready", 64'(got_io_rdy), 64'd1);
        check("r0_we", 64'(ctrl_writeEnable), 64'd0);
        io_valid = 0;

        // Scoreboard set, stall, clear, and same-cycle set/clear.
        md_issue = 1; md_issue_reg = 5'd7;
        tick();
        md_issue = 0;
        check("sb_set7", 64'(busy_vec[7]), 64'd1);
        rd_regB = 5'd7;
        tick();
        check("sb_stall7", 64'(got_stall), 64'd1);
        tick();
        md_valid = 1; md_reg = 5'd7; md_data = 32'h0000_0777;
        tick();
        check("sb_md7_rdy", 64'(got_md_rdy), 64'd1);
        check("sb_clr7", 64'(busy_vec[7]), 64'd0);
        md_issue = 1; md_issue_reg = 5'd9; md_reg = 5'd9; md_data = 32'h0000_0999;
        tick();
        check("sb_md9_rdy", 64'(got_md_rdy), 64'd1);
        check("sb_setwins9", 64'(busy_vec[9]), 64'd1);
        quiet();

`ifdef REGFILE_ARB_FWD_EN
        wb_valid = 1; wb_reg = 5'd3; wb_data = 32'h0000_1234;
        tick();
        wb_valid = 0; rd_regA = 5'd3;
        #1;
        check("fwd_hit3", 64'(fwd_hitA), 64'd1);
        check("fwd_data3", 64'(fwd_data), 64'h1234);
        rd_regA = 5'd4;
        #1;
        check("fwd_miss4", 64'(fwd_hitA), 64'd0);
        tick();
`endif

        // Random traffic; requesters hold their request until accepted.
        for (int c = 0; c < 600; c++) begin
            ctrl_reset   = ($urandom_range(0, 99) == 0);
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_reg       = AW'($urandom_range(0, 15));
            wb_data      = $urandom;
            md_issue     = ($urandom_range(0, 3) == 0);
            md_issue_reg = AW'($urandom_range(0, 15));
            rd_regA      = AW'($urandom_range(0, 15));
            rd_regB      = AW'($urandom_range(0, 15));
            if (!md_valid || got_md_rdy) begin
                md_valid = $urandom_range(0, 1) == 1;
                md_reg   = AW'($urandom_range(0, 15));
                md_data  = $urandom;
            end
            if (!io_valid || got_io_rdy) begin
                io_valid = $urandom_range(0, 1) == 1;
                io_reg   = AW'($urandom_range(0, 4));
                io_data  = $urandom;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
